// File: rtl/key_press_pkg.sv
`default_nettype none
// key_press_pkg: shared FSM state type and counter-width helper for the key press array.

package key_press_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      DISARMING = 2'd3
   } key_state_e;

   // Bits needed to hold values 0..max_count inclusive.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// key_channel: synchroniser, debounce FSM and registered outputs for one key.
// Auto-repeat of a held key is compiled in when KEY_AUTOREPEAT_EN is defined.

module key_channel
   import key_press_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic held_o,
   output logic press_o,
   output logic release_o
);

   localparam int            CW         = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES);
   localparam bit            C_DIRECT   = (DEBOUNCE_CYCLES == 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("key_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic          sync1_q, sync2_q;
   key_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          held_q, held_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          fsm_press;
   logic          rep_fire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         held_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= in_i;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fsm_press = 1'b0;
      release_d = 1'b0;
      cnt_inc   = cnt_q + C_CNT_ONE;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               if (C_DIRECT) begin
                  state_d   = HELD;
                  fsm_press = 1'b1;
               end else begin
                  state_d = ARMING;
                  cnt_d   = C_CNT_ONE;
               end
            end
         end
         ARMING: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == C_CNT_LAST) begin
               state_d   = HELD;
               cnt_d     = '0;
               fsm_press = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               if (C_DIRECT) begin
                  state_d   = IDLE;
                  release_d = 1'b1;
               end else begin
                  state_d = DISARMING;
                  cnt_d   = C_CNT_ONE;
               end
            end
         end
         DISARMING: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_inc == C_CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d = (state_d == HELD) || (state_d == DISARMING);
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int            RMAX         = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW           = cnt_width(RMAX);
   localparam logic [RW-1:0] C_REP_ONE    = RW'(1);
   localparam logic [RW-1:0] C_REP_DELAY  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] C_REP_PERIOD = RW'(REPEAT_PERIOD);

   logic [RW-1:0] rep_q, rep_d, rep_inc;
   logic          rep_phase_q, rep_phase_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rep_q       <= '0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_q       <= rep_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   // Counts only while the key stays solidly held; a bounce freezes it and
   // returning to HELD restarts the initial delay.
   always_comb begin
      rep_d       = rep_q;
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      rep_inc     = rep_q + C_REP_ONE;
      if (state_q == HELD && sync2_q) begin
         if (rep_inc == (rep_phase_q ? C_REP_PERIOD : C_REP_DELAY)) begin
            rep_fire    = 1'b1;
            rep_d       = '0;
            rep_phase_d = 1'b1;
         end else begin
            rep_d = rep_inc;
         end
      end else if (!(state_q == HELD || state_q == DISARMING) || sync2_q) begin
         rep_d       = '0;
         rep_phase_d = 1'b0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign press_d   = fsm_press | rep_fire;
   assign held_o    = held_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/key_press_array.sv
`default_nettype none
// key_press_array: CHANNELS independent debounced keys with press/release pulses.
// Define KEY_AUTOREPEAT_EN to turn a held key into a periodic press-pulse train.

module key_press_array
   import key_press_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [CHANNELS-1:0] in_i,
   output logic [CHANNELS-1:0] held_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o
);

   if (CHANNELS < 1) begin : g_param_check
      $error("key_press_array: CHANNELS must be >= 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_key_channel (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .in_i     (in_i[i]),
         .held_o   (held_o[i]),
         .press_o  (press_o[i]),
         .release_o(release_o[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_key_press_array.sv
`default_nettype none
// tb_key_press_array: directed and random stimulus for key_press_array, checked
// against a sample-window model of debounce (plus auto-repeat timing when enabled).

module tb_key_press_array;

   localparam int CH = 4;
   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] in_v;
   logic [CH-1:0] held, press, rel;

   int total = 0;
   int bad   = 0;

   // Model state: raw input history, per-channel window of synchronised samples.
   logic [CH-1:0] raw_q[$];
   bit            shist[CH][$];
   logic [CH-1:0] m_held, m_press, m_rel;
   int            cyc = 0;
   int            t_ref[CH];
   bit            frozen[CH];

   always #5 clk = ~clk;

   key_press_array #(
      .CHANNELS       (CH),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .in_i     (in_v),
      .held_o   (held),
      .press_o  (press),
      .release_o(rel)
   );

   task automatic model_clear();
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      for (int c = 0; c < CH; c++) begin
         shist[c].delete();
         t_ref[c]  = 0;
         frozen[c] = 1'b0;
      end
      m_held  = '0;
      m_press = '0;
      m_rel   = '0;
   endtask

   // Advance one clock edge, update the model with the input seen at that edge,
   // then move 1 time unit past the edge so outputs can be sampled.
   task automatic tick();
      logic [CH-1:0] s;
      bit            all_diff;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         model_clear();
      end else begin
         raw_q.push_back(in_v);
         s       = raw_q.pop_front();
         m_press = '0;
         m_rel   = '0;
         for (int c = 0; c < CH; c++) begin
            shist[c].push_back(s[c]);
            if (shist[c].size() > DB) void'(shist[c].pop_front());
            all_diff = (shist[c].size() == DB);
            for (int k = 0; k < shist[c].size(); k++)
               if (shist[c][k] == m_held[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_held[c] = ~m_held[c];
               if (m_held[c]) begin
                  m_press[c] = 1'b1;
                  t_ref[c]   = cyc;
                  frozen[c]  = 1'b0;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (m_held[c]) begin
               if (!s[c]) frozen[c] = 1'b1;
               else if (frozen[c]) begin
                  frozen[c] = 1'b0;
                  t_ref[c]  = cyc;
               end else if ((cyc - t_ref[c]) >= RD && ((cyc - t_ref[c] - RD) % RP) == 0)
                  m_press[c] = 1'b1;
            end
`endif
         end
      end
      #1;
   endtask

   task automatic test_reset();
      in_v  = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({held, press, rel} !== 12'b0) begin
         bad++;
         $display("FAIL reset_async got held=%b press=%b rel=%b exp all 0", held, press, rel);
      end
      model_clear();
      repeat (2) begin
         tick();
         total++;
         if ({held, press, rel} !== 12'b0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got held=%b press=%b rel=%b exp all 0", cyc, held, press, rel);
         end
      end
      rst_n = 1'b1;
      repeat (10) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
      end
   endtask

   task automatic test_latency();
      int first = 0;
      int np    = 0;
      in_v[0] = 1'b1;
      for (int n = 1; n <= 26; n++) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL latency_model cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (press[0]) begin
            np++;
            if (first == 0) first = n;
         end
      end
      total++;
      if (first != DB + 2) begin
         bad++;
         $display("FAIL press_latency got edge %0d exp edge %0d", first, DB + 2);
      end
`ifndef KEY_AUTOREPEAT_EN
      total++;
      if (np != 1) begin
         bad++;
         $display("FAIL press_once got %0d pulses exp 1", np);
      end
`endif
      in_v[0] = 1'b0;
      first   = 0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL release_model cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (rel[0] && first == 0) first = n;
      end
      total++;
      if (first != DB + 2) begin
         bad++;
         $display("FAIL release_latency got edge %0d exp edge %0d", first, DB + 2);
      end
   endtask

   task automatic test_glitch();
      logic [5:0] pat = 6'b111101;
      int         np  = 0;
      in_v[1] = 1'b1;
      for (int n = 1; n <= 11; n++) begin
         if (n == 4) in_v[1] = 1'b0;
         tick();
         total++;
         if (held[1] !== 1'b0 || press[1] !== 1'b0 ||
             {held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL short_pulse cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
      end
      for (int n = 0; n < 16; n++) begin
         in_v[1] = (n < 6) ? pat[n] : 1'b1;
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL bounce_model cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (press[1]) np++;
      end
`ifndef KEY_AUTOREPEAT_EN
      total++;
      if (np != 1) begin
         bad++;
         $display("FAIL bounce_press got %0d pulses exp 1", np);
      end
`endif
      total++;
      if (held[1] !== 1'b1) begin
         bad++;
         $display("FAIL bounce_held got %b exp 1", held[1]);
      end
      in_v[1] = 1'b0;
      repeat (12) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL bounce_release cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
      end
   endtask

   task automatic test_release_glitch();
      int nr = 0;
      in_v[2] = 1'b1;
      for (int n = 0; n < 34; n++) begin
         if (n == 12) in_v[2] = 1'b0;
         if (n == 14) in_v[2] = 1'b1;
         if (n == 22) in_v[2] = 1'b0;
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL release_glitch cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (rel[2]) begin
            nr++;
            total++;
            if (n < 22) begin
               bad++;
               $display("FAIL dropout_release got release at step %0d exp none before step 22", n);
            end
         end
      end
      total++;
      if (nr != 1 || held[2] !== 1'b0) begin
         bad++;
         $display("FAIL release_once got %0d pulses held=%b exp 1 pulse held=0", nr, held[2]);
      end
   endtask

   task automatic test_simultaneous();
      int first = 0;
      in_v = 4'b1001;
      for (int n = 1; n <= 10; n++) begin
         tick();
         total++;
         if (press[0] !== press[3] || {held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL simultaneous cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (press[0] && first == 0) first = n;
      end
      total++;
      if (first != DB + 2) begin
         bad++;
         $display("FAIL simul_latency got edge %0d exp edge %0d", first, DB + 2);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({held, press, rel} !== 12'b0) begin
         bad++;
         $display("FAIL midrun_reset got held=%b press=%b rel=%b exp all 0", held, press, rel);
      end
      model_clear();
      repeat (2) tick();
      rst_n = 1'b1;
      first = 0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL post_reset cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (press[3] && first == 0) first = n;
      end
      total++;
      if (first != DB + 2) begin
         bad++;
         $display("FAIL post_reset_latency got edge %0d exp edge %0d", first, DB + 2);
      end
      in_v = '0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 4) == 0) in_v[c] = ~in_v[c];
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel} || (press & rel) !== '0) begin
            bad++;
            $display("FAIL random cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
      end
      in_v = '0;
      repeat (15) begin
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL random_settle cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
      end
   endtask

`ifdef KEY_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int  t0       = -1;
      int  np       = 0;
      int  off;
      bit  rel_seen = 1'b0;
      in_v[0] = 1'b1;
      for (int n = 1; n <= 56; n++) begin
         if (n == 37) in_v[0] = 1'b0;
         tick();
         total++;
         if ({held, press, rel} !== {m_held, m_press, m_rel}) begin
            bad++;
            $display("FAIL repeat_model cyc=%0d got h=%b p=%b r=%b exp h=%b p=%b r=%b",
                     cyc, held, press, rel, m_held, m_press, m_rel);
         end
         if (rel[0]) rel_seen = 1'b1;
         if (press[0]) begin
            if (t0 < 0) t0 = n;
            off = n - t0;
            if (n <= 36) np++;
            total++;
            if (rel_seen || !(off == 0 || (off >= RD && ((off - RD) % RP) == 0))) begin
               bad++;
               $display("FAIL repeat_timing got press at offset %0d (released=%b) exp 0 or %0d+k*%0d",
                        off, rel_seen, RD, RP);
            end
         end
      end
      total++;
      if (np != 7 || !rel_seen) begin
         bad++;
         $display("FAIL repeat_count got %0d presses released=%b exp 7 presses released=1", np, rel_seen);
      end
   endtask
`endif

   initial begin
      in_v  = '0;
      rst_n = 1'b1;
      model_clear();
      test_reset();
      test_latency();
      test_glitch();
      test_release_glitch();
      test_simultaneous();
      test_random();
`ifdef KEY_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
